// File: rtl/wb_tc8_pkg.sv
// Shared constants for the wb_tc8 timer/counter: register addresses,
// CTRL/STATUS bit positions and the counter width.
package wb_tc8_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_PRESC  = 8'h01;
    localparam logic [7:0] ADR_TOP_L  = 8'h02;
    localparam logic [7:0] ADR_TOP_H  = 8'h03;
    localparam logic [7:0] ADR_CMP_L  = 8'h04;
    localparam logic [7:0] ADR_CMP_H  = 8'h05;
    localparam logic [7:0] ADR_CNT_L  = 8'h06;
    localparam logic [7:0] ADR_CNT_H  = 8'h07;
    localparam logic [7:0] ADR_CAP_L  = 8'h08;
    localparam logic [7:0] ADR_CAP_H  = 8'h09;
    localparam logic [7:0] ADR_STATUS = 8'h0A;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_OC_EN  = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IC_EN  = 3;
    localparam int CTRL_IE_OVF = 4;
    localparam int CTRL_IE_CMP = 5;
    localparam int CTRL_IE_IC  = 6;

    localparam int ST_OVF = 0;
    localparam int ST_CMP = 1;
    localparam int ST_IC  = 2;
    localparam int ST_W   = 3;

endpackage

// File: rtl/wb_tc8_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse. A high level sampled at edge k yields pulse=1 during the
// cycle after edge k+2.
module wb_tc8_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       pulse_reg;

    // Synchronize, remember the previous synchronized level, register the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= 2'b00;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], din};
            prev_reg  <= sync_reg[1];
            pulse_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/wb_tc8.sv
// Wishbone classic responder with an 8-bit register file controlling a 16-bit
// prescaled timer/counter with compare toggle output, input capture and a
// level interrupt.
module wb_tc8
    import wb_tc8_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_TOP = 16'hFFFF,
    parameter logic [CNT_W-1:0] RESET_CMP = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       tc_ic,
    output logic       tc_oc,
    output logic       tc_int
);

    // Bus state
    logic             ack_reg;
    logic [7:0]       dat_reg;

    // Register file
    logic [6:0]       ctrl_reg;
    logic [7:0]       presc_reg;
    logic [CNT_W-1:0] top_reg;
    logic [CNT_W-1:0] cmp_reg;
    logic [7:0]       top_stage_reg;
    logic [7:0]       cmp_stage_reg;
    logic [7:0]       cnt_shadow_reg;
    logic [7:0]       cap_shadow_reg;
    logic [ST_W-1:0]  status_reg;
    logic [ST_W-1:0]  status_next;

    // Timer state
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       pcnt_reg;
    logic [CNT_W-1:0] cap_reg;
    logic             oc_reg;
    logic             int_reg;

    logic             bus_req;
    logic             bus_wr;
    logic             bus_rd;
    logic [7:0]       rd_data;
    logic             clr;
    logic             tick;
    logic             cnt_upd;
    logic             wrap_hit;
    logic             cmp_hit;
    logic             ic_pulse;
    logic             cap_hit;
    logic [ST_W-1:0]  flag_set;
    logic [ST_W-1:0]  flag_clr;

    wb_tc8_sync_edge u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (tc_ic),
        .pulse (ic_pulse)
    );

    // A request is only accepted while ack is low, so held strobes ack every other cycle.
    assign bus_req = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign bus_wr  = bus_req & wb_we_i;
    assign bus_rd  = bus_req & ~wb_we_i;

    // CLR overrides a tick landing on the same edge.
    assign clr      = bus_wr && (wb_adr_i == ADR_CTRL) && wb_dat_i[CTRL_CLR];
    assign tick     = ctrl_reg[CTRL_EN] && (pcnt_reg == presc_reg);
    assign cnt_upd  = tick && !clr;
    assign wrap_hit = cnt_upd && (cnt_reg == top_reg);
    assign cmp_hit  = cnt_upd && (cnt_reg == cmp_reg);
    assign cap_hit  = ic_pulse && ctrl_reg[CTRL_IC_EN];

    assign flag_set = {cap_hit, cmp_hit, wrap_hit};
    assign flag_clr = (bus_wr && (wb_adr_i == ADR_STATUS)) ? wb_dat_i[ST_W-1:0] : '0;

    // Per-flag next state: a hardware set wins over a write-1-to-clear.
    for (genvar gi = 0; gi < ST_W; gi++) begin : g_flag
        assign status_next[gi] = flag_set[gi] | (status_reg[gi] & ~flag_clr[gi]);
    end

    // Read data mux; 16-bit high halves come from shadows latched by the low read.
    always_comb begin
        rd_data = 8'h00;
        case (wb_adr_i)
            ADR_CTRL:   rd_data = {1'b0, ctrl_reg};
            ADR_PRESC:  rd_data = presc_reg;
            ADR_TOP_L:  rd_data = top_reg[7:0];
            ADR_TOP_H:  rd_data = top_reg[15:8];
            ADR_CMP_L:  rd_data = cmp_reg[7:0];
            ADR_CMP_H:  rd_data = cmp_reg[15:8];
            ADR_CNT_L:  rd_data = cnt_reg[7:0];
            ADR_CNT_H:  rd_data = cnt_shadow_reg;
            ADR_CAP_L:  rd_data = cap_reg[7:0];
            ADR_CAP_H:  rd_data = cap_shadow_reg;
            ADR_STATUS: rd_data = {{(8-ST_W){1'b0}}, status_reg};
            default:    rd_data = 8'h00;
        endcase
    end

    // Bus handshake, register writes and read-side shadow latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg        <= 1'b0;
            dat_reg        <= 8'h00;
            ctrl_reg       <= 7'h00;
            presc_reg      <= 8'h00;
            top_reg        <= RESET_TOP;
            cmp_reg        <= RESET_CMP;
            top_stage_reg  <= 8'h00;
            cmp_stage_reg  <= 8'h00;
            cnt_shadow_reg <= 8'h00;
            cap_shadow_reg <= 8'h00;
        end else begin
            ack_reg <= bus_req;
            if (bus_req) begin
                dat_reg <= rd_data;
            end
            if (bus_rd && (wb_adr_i == ADR_CNT_L)) begin
                cnt_shadow_reg <= cnt_reg[15:8];
            end
            if (bus_rd && (wb_adr_i == ADR_CAP_L)) begin
                cap_shadow_reg <= cap_reg[15:8];
            end
            if (bus_wr) begin
                case (wb_adr_i)
                    ADR_CTRL:  ctrl_reg      <= wb_dat_i[6:0] & ~(7'd1 << CTRL_CLR);
                    ADR_PRESC: presc_reg     <= wb_dat_i;
                    ADR_TOP_L: top_stage_reg <= wb_dat_i;
                    ADR_TOP_H: top_reg       <= {wb_dat_i, top_stage_reg};
                    ADR_CMP_L: cmp_stage_reg <= wb_dat_i;
                    ADR_CMP_H: cmp_reg       <= {wb_dat_i, cmp_stage_reg};
                    default:   ;
                endcase
            end
        end
    end

    // Prescaler, counter, compare toggle, capture, flags and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg   <= 8'h00;
            cnt_reg    <= '0;
            cap_reg    <= '0;
            oc_reg     <= 1'b0;
            status_reg <= '0;
            int_reg    <= 1'b0;
        end else begin
            if (clr) begin
                pcnt_reg <= 8'h00;
                cnt_reg  <= '0;
            end else if (ctrl_reg[CTRL_EN]) begin
                pcnt_reg <= (pcnt_reg == presc_reg) ? 8'h00 : pcnt_reg + 8'd1;
                if (tick) begin
                    cnt_reg <= (cnt_reg == top_reg) ? '0 : cnt_reg + 16'd1;
                end
            end
            if (cmp_hit && ctrl_reg[CTRL_OC_EN]) begin
                oc_reg <= ~oc_reg;
            end
            if (cap_hit) begin
                cap_reg <= cnt_reg;
            end
            status_reg <= status_next;
            int_reg    <= |(status_reg & {ctrl_reg[CTRL_IE_IC], ctrl_reg[CTRL_IE_CMP],
                                          ctrl_reg[CTRL_IE_OVF]});
        end
    end

    assign wb_ack_o = ack_reg;
    assign wb_dat_o = dat_reg;
    assign tc_oc    = oc_reg;
    assign tc_int   = int_reg;

endmodule

// File: tb/tb_wb_tc8.sv
// Directed, table-driven bench for wb_tc8 with hand-written multi-cycle sequences.
module tb_wb_tc8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc, stb, we;
    logic [7:0] adr, dat_i, dat_o;
    logic       ack;
    logic       tc_ic, tc_oc, tc_int;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int last_ack;
    logic [7:0] last_dat;

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[26];

    wb_tc8 dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .tc_ic    (tc_ic),
        .tc_oc    (tc_oc),
        .tc_int   (tc_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transfer; leaves last_ack = edge number of the ack, last_dat = wb_dat_o.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got = 0;
        last_ack = -1;
        last_dat = 8'h00;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        for (int n = 0; n < 4 && !got; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1;
                last_ack = cyc_cnt;
                last_dat = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: adr 0x%0h got no ack, expected ack", a);
        end
        $display("[TB] %s adr=0x%02h wdat=0x%02h rdat=0x%02h ack@%0d", w ? "WR" : "RD", a, d, last_dat, last_ack);
    endtask

    // Idle until the next transfer's ack edge e satisfies (e - base) % 4 == want.
    task automatic wait_phase(input int base, input int want);
        @(posedge clk); #1;
        for (int n = 0; n < 8 && (((cyc_cnt + 1 - base) % 4) != want); n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc_cnt < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, ea, k, acks;

        vecs[0]  = '{1'b0, 8'h02, 8'h00, 1'b1, 8'hFF};
        vecs[1]  = '{1'b0, 8'h03, 8'h00, 1'b1, 8'hFF};
        vecs[2]  = '{1'b0, 8'h04, 8'h00, 1'b1, 8'hFF};
        vecs[3]  = '{1'b0, 8'h05, 8'h00, 1'b1, 8'hFF};
        vecs[4]  = '{1'b0, 8'h0A, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 8'h06, 8'h00, 1'b1, 8'h00};
        vecs[7]  = '{1'b0, 8'h08, 8'h00, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 8'h01, 8'h5A, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h01, 8'h00, 1'b1, 8'h5A};
        vecs[10] = '{1'b1, 8'h3F, 8'hAA, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 8'h3F, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{1'b1, 8'h02, 8'h03, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 8'h03, 8'h00, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 8'h02, 8'h00, 1'b1, 8'h03};
        vecs[15] = '{1'b0, 8'h03, 8'h00, 1'b1, 8'h00};
        vecs[16] = '{1'b1, 8'h04, 8'h02, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 8'h04, 8'h00, 1'b1, 8'hFF};
        vecs[18] = '{1'b1, 8'h05, 8'h00, 1'b0, 8'h00};
        vecs[19] = '{1'b0, 8'h04, 8'h00, 1'b1, 8'h02};
        vecs[20] = '{1'b0, 8'h05, 8'h00, 1'b1, 8'h00};
        vecs[21] = '{1'b1, 8'h00, 8'h76, 1'b0, 8'h00};
        vecs[22] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h72};
        vecs[23] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[24] = '{1'b1, 8'h01, 8'h00, 1'b0, 8'h00};
        vecs[25] = '{1'b0, 8'h01, 8'h00, 1'b1, 8'h00};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 8'h00; dat_i = 8'h00; tc_ic = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ack", ack, 0);
        check("rst_dat", dat_o, 0);
        check("rst_oc", tc_oc, 0);
        check("rst_int", tc_int, 0);

        // Register-level vectors
        for (int i = 0; i < 26; i++) begin
            xfer(vecs[i].wr, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) check($sformatf("vec%0d_adr%02h", i, vecs[i].a), last_dat, vecs[i].exp);
        end

        // PRESC=0, TOP=3, CMP=2: count 1,2,3,0 with OVF on the wrap
        xfer(1'b1, 8'h00, 8'h11);
        e0 = last_ack;
        for (int d = 1; d <= 5; d++) begin
            @(posedge clk); #1;
            check($sformatf("ovf_int_d%0d", d), tc_int, (d >= 5));
        end
        xfer(1'b0, 8'h0A, 8'h00);
        check("status_ovf_cmp", last_dat, 8'h03);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'h06, 8'h00);
            check($sformatf("cnt_seq%0d", i), last_dat, 16'((last_ack - 1 - e0) % 4));
            repeat (2) @(posedge clk);
        end

        // W1C away from a wrap clears OVF and drops the interrupt
        wait_phase(e0, 1);
        xfer(1'b1, 8'h0A, 8'h01);
        @(posedge clk); #1;
        check("w1c_int_drop", tc_int, 0);
        xfer(1'b0, 8'h0A, 8'h00);
        check("w1c_status", last_dat, 8'h02);

        // W1C on the wrap edge: OVF stays set
        wait_phase(e0, 0);
        xfer(1'b1, 8'h0A, 8'h03);
        xfer(1'b0, 8'h0A, 8'h00);
        check("w1c_vs_wrap", last_dat, 8'h01);

        // CLR on a tick edge restarts from 0
        wait_phase(e0, 2);
        xfer(1'b1, 8'h00, 8'h15);
        ea = last_ack;
        xfer(1'b0, 8'h06, 8'h00);
        check("clr_cnt_l", last_dat, 16'((last_ack - 1 - ea) % 4));
        xfer(1'b0, 8'h07, 8'h00);
        check("clr_cnt_h", last_dat, 8'h00);

        // Compare toggle: PRESC=3, CMP=2, TOP=3
        xfer(1'b1, 8'h00, 8'h04);
        xfer(1'b1, 8'h0A, 8'h07);
        xfer(1'b1, 8'h01, 8'h03);
        xfer(1'b1, 8'h00, 8'h23);
        e1 = last_ack;
        for (int d = 1; d <= 30; d++) begin
            @(posedge clk); #1;
            check($sformatf("oc_d%0d", d), tc_oc, (d >= 12 && d < 28));
            check($sformatf("cmp_int_d%0d", d), tc_int, (d >= 13));
        end
        xfer(1'b0, 8'h0A, 8'h00);
        check("cmp_status", last_dat, 8'h03);

        // Capture at CNT=0x1234
        xfer(1'b1, 8'h00, 8'h04);
        xfer(1'b1, 8'h02, 8'hFF);
        xfer(1'b1, 8'h03, 8'hFF);
        xfer(1'b1, 8'h01, 8'h00);
        xfer(1'b1, 8'h0A, 8'h07);
        xfer(1'b1, 8'h00, 8'h49);
        e2 = last_ack;
        k = e2 + 32'h1234 - 2;
        wait_until(k - 1);
        @(negedge clk);
        tc_ic = 1'b1;
        for (int d = 0; d <= 4; d++) begin
            @(posedge clk); #1;
            check($sformatf("ic_int_d%0d", d), tc_int, (d == 4));
        end
        xfer(1'b0, 8'h08, 8'h00);
        check("cap_l", last_dat, 8'h34);
        xfer(1'b0, 8'h09, 8'h00);
        check("cap_h", last_dat, 8'h12);
        xfer(1'b0, 8'h0A, 8'h00);
        check("ic_status", last_dat, 8'h06);

        // No capture with IC_EN=0
        xfer(1'b1, 8'h00, 8'h41);
        tc_ic = 1'b0;
        repeat (5) @(posedge clk);
        xfer(1'b1, 8'h0A, 8'h07);
        @(negedge clk);
        tc_ic = 1'b1;
        repeat (6) @(posedge clk);
        xfer(1'b0, 8'h0A, 8'h00);
        check("noic_status", last_dat, 8'h00);
        xfer(1'b0, 8'h08, 8'h00);
        check("noic_cap_l", last_dat, 8'h34);

        // Strobe held for two cycles gives exactly one ack
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h01;
        acks = 0;
        repeat (2) begin
            @(posedge clk); #1;
            acks += int'(ack);
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_stb_acks", 16'(acks), 1);
        $display("[TB] held strobe acks=%0d", acks);

        // Strobe without cycle: no ack and no write
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 8'h01; dat_i = 8'h99;
        @(posedge clk); #1;
        check("abort_no_ack", ack, 0);
        stb = 1'b0; we = 1'b0;
        xfer(1'b0, 8'h01, 8'h00);
        check("abort_no_write", last_dat, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
